// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Brief    : Shared encodings and Memory_System port addresses for mem_arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

  localparam logic [0:0]  IDLE         = 1'b0;
  localparam logic [0:0]  ACCESS       = 1'b1;

  localparam logic [0:0]  M0           = 1'b0;
  localparam logic [0:0]  M1           = 1'b1;

  localparam logic [31:0] OUTPORT_ADDR = 32'h003F_FFC0;
  localparam logic [31:0] INPORT_ADDR  = 32'h003F_FFBC;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_arbiter_if
// Brief     : Requester handshakes plus the Memory_System bus of mem_arbiter.
// Revision  : 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  m0_req,   m1_req;
  logic                  m0_we,    m1_we;
  logic [31:0]           m0_addr,  m1_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m1_wdata;
  logic                  m0_gnt,   m1_gnt;
  logic                  m0_done,  m1_done;
  logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
  logic                  m0_err,   m1_err;

  logic                  Write_Enable_o;
  logic [31:0]           Address_o;
  logic [DATA_WIDTH-1:0] Write_Data_o;
  logic [DATA_WIDTH-1:0] Read_Data_i;

  // Arbiter side
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, m0_err, m1_err,
    output Write_Enable_o, Address_o, Write_Data_o,
    input  Read_Data_i
  );

  // Requesters and memory side
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, m0_err, m1_err,
    input  Write_Enable_o, Address_o, Write_Data_o,
    output Read_Data_i
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin pick; owns the last-granted id register.
// Revision : 1.0
// ============================================================================
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  wire  CLK,
  input  wire  RST,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic winner,
  output logic any_req
);

  logic last_q, last_d;

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) winner = ~last_q;
    else if (req1)    winner = M1;
    else              winner = M0;
    last_d = advance ? winner : last_q;
  end

  // Reset to M1 so that m0 wins the first tie
  always_ff @(posedge CLK) begin
    if (RST) last_q <= M1;
    else     last_q <= last_d;
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing Memory_System between m0 and m1.
// Revision : 1.0
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  wire          CLK,
  input  wire          RST,
  mem_arbiter_if.slave bus
);

  logic [0:0]            state_q, state_d;
  logic                  id_q,    id_d;
  logic                  we_q,    we_d;
  logic [31:0]           addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;

  logic winner, any_req, advance, aligned;

  assign advance = (state_q == IDLE) && any_req;
  assign aligned = is_aligned(addr_q);

  rr_arbiter2 u_rr (
    .CLK     (CLK),
    .RST     (RST),
    .req0    (bus.m0_req),
    .req1    (bus.m1_req),
    .advance (advance),
    .winner  (winner),
    .any_req (any_req)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the memory bus is parked at address 0 (ROM) outside ACCESS
  always_comb begin
    bus.m0_gnt         = (state_q == ACCESS) && (id_q == M0);
    bus.m1_gnt         = (state_q == ACCESS) && (id_q == M1);
    bus.Address_o      = (state_q == ACCESS) ? addr_q  : '0;
    bus.Write_Data_o   = (state_q == ACCESS) ? wdata_q : '0;
    bus.Write_Enable_o = (state_q == ACCESS) && we_q && aligned;
    bus.m0_done        = done0_q;
    bus.m1_done        = done1_q;
    bus.m0_rdata       = rdata0_q;
    bus.m1_rdata       = rdata1_q;
    bus.m0_err         = err0_q;
    bus.m1_err         = err1_q;
  end

  // Request capture in IDLE, completion capture at the end of ACCESS
  always_comb begin
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    if (advance) begin
      id_d    = winner;
      we_d    = (winner == M1) ? bus.m1_we    : bus.m0_we;
      addr_d  = (winner == M1) ? bus.m1_addr  : bus.m0_addr;
      wdata_d = (winner == M1) ? bus.m1_wdata : bus.m0_wdata;
    end
    if (state_q == ACCESS) begin
      if (id_q == M1) begin
        rdata1_d = bus.Read_Data_i;
        err1_d   = ~aligned;
        done1_d  = 1'b1;
      end else begin
        rdata0_d = bus.Read_Data_i;
        err0_d   = ~aligned;
        done0_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      id_q     <= M0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a Memory_System model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] ram [0:15];
  logic [31:0] outport;
  logic [31:0] inport;

  mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

  mem_arbiter #(.DATA_WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory_System model: RAM at 0x1001_0000 (16 words), I/O ports, ROM elsewhere
  always_comb begin
    if (bus.Address_o[31:6] == 26'h040_0400) bus.Read_Data_i = ram[bus.Address_o[5:2]];
    else if (bus.Address_o == INPORT_ADDR)   bus.Read_Data_i = inport;
    else if (bus.Address_o == OUTPORT_ADDR)  bus.Read_Data_i = outport;
    else                                     bus.Read_Data_i = {16'hC0DE, bus.Address_o[15:0]};
  end

  always @(posedge clk) begin
    if (bus.Write_Enable_o) begin
      if (bus.Address_o[31:6] == 26'h040_0400) ram[bus.Address_o[5:2]] <= bus.Write_Data_o;
      else if (bus.Address_o == OUTPORT_ADDR)  outport <= bus.Write_Data_o;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done} !== 4'b0) begin failures++; $display("FAIL reset_gnt_done: got %b expected 0000", {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done}); end
    checks++; if ({bus.m0_err, bus.m1_err} !== 2'b0) begin failures++; $display("FAIL reset_err: got %b expected 00", {bus.m0_err, bus.m1_err}); end
    checks++; if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.m0_rdata, bus.m1_rdata); end
    checks++; if (bus.Address_o !== 32'h0 || bus.Write_Data_o !== 32'h0 || bus.Write_Enable_o !== 1'b0) begin failures++; $display("FAIL reset_membus: got a=%h d=%h we=%b expected 0", bus.Address_o, bus.Write_Data_o, bus.Write_Enable_o); end
  endtask

  task automatic test_m0_read;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1001_0004;
    @(negedge clk);
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin failures++; $display("FAIL read_gnt: got %b expected 10", {bus.m0_gnt, bus.m1_gnt}); end
    checks++; if (bus.Address_o !== 32'h1001_0004 || bus.Write_Enable_o !== 1'b0) begin failures++; $display("FAIL read_bus: got a=%h we=%b expected 10010004/0", bus.Address_o, bus.Write_Enable_o); end
    checks++; if (bus.m0_done !== 1'b0) begin failures++; $display("FAIL read_early_done: got %b expected 0", bus.m0_done); end
    bus.m0_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m0_done, bus.m1_done, bus.m0_gnt} !== 3'b100) begin failures++; $display("FAIL read_done: got %b expected 100", {bus.m0_done, bus.m1_done, bus.m0_gnt}); end
    checks++; if (bus.m0_rdata !== 32'hDEAD_BEEF || bus.m0_err !== 1'b0) begin failures++; $display("FAIL read_data: got %h err=%b expected deadbeef err=0", bus.m0_rdata, bus.m0_err); end
    checks++; if (bus.Address_o !== 32'h0) begin failures++; $display("FAIL read_idle_addr: got %h expected 0", bus.Address_o); end
    @(negedge clk);
    checks++; if (bus.m0_done !== 1'b0 || bus.m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_hold: got done=%b rdata=%h expected 0/deadbeef", bus.m0_done, bus.m0_rdata); end
  endtask

  task automatic test_outport_write;
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = OUTPORT_ADDR; bus.m0_wdata = 32'h0000_00A5;
    @(negedge clk);
    checks++; if (bus.Write_Enable_o !== 1'b1 || bus.Address_o !== OUTPORT_ADDR || bus.Write_Data_o !== 32'hA5) begin failures++; $display("FAIL wr_bus: got we=%b a=%h d=%h expected 1/003fffc0/a5", bus.Write_Enable_o, bus.Address_o, bus.Write_Data_o); end
    checks++; if (outport !== 32'h0) begin failures++; $display("FAIL wr_early: got %h expected 0", outport); end
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    @(negedge clk);
    checks++; if (outport !== 32'hA5 || bus.Write_Enable_o !== 1'b0) begin failures++; $display("FAIL wr_commit: got out=%h we=%b expected a5/0", outport, bus.Write_Enable_o); end
    checks++; if (bus.m0_done !== 1'b1 || bus.m0_rdata !== 32'h0) begin failures++; $display("FAIL wr_done: got done=%b rdata=%h expected 1/0", bus.m0_done, bus.m0_rdata); end
    checks++; if ({bus.m1_done, bus.m1_err} !== 2'b00 || bus.m1_rdata !== 32'h0) begin failures++; $display("FAIL wr_m1_quiet: got %b rdata=%h expected 00/0", {bus.m1_done, bus.m1_err}, bus.m1_rdata); end
  endtask

  task automatic test_misaligned;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h1001_0002; bus.m1_wdata = 32'hBADB_AD00;
    @(negedge clk);
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01 || bus.Write_Enable_o !== 1'b0) begin failures++; $display("FAIL mis_access: got gnt=%b we=%b expected 01/0", {bus.m0_gnt, bus.m1_gnt}, bus.Write_Enable_o); end
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m1_done, bus.m1_err, bus.m0_done} !== 3'b110) begin failures++; $display("FAIL mis_done: got %b expected 110", {bus.m1_done, bus.m1_err, bus.m0_done}); end
    checks++; if (ram[0] !== 32'h1111_0000 || bus.m1_rdata !== 32'h1111_0000) begin failures++; $display("FAIL mis_data: got ram=%h rdata=%h expected 11110000", ram[0], bus.m1_rdata); end
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1001_0008;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h1001_000C;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_sel  = (((k / 2) % 2) == 0) ? 2'b10 : 2'b01;
      exp_data = (exp_sel == 2'b10) ? 32'h1111_0002 : 32'h1111_0003;
      if ((k % 2) == 0) begin
        checks++; if ({bus.m0_gnt, bus.m1_gnt} !== exp_sel || {bus.m0_done, bus.m1_done} !== 2'b00) begin failures++; $display("FAIL rr_gnt[%0d]: got gnt=%b done=%b expected %b/00", k, {bus.m0_gnt, bus.m1_gnt}, {bus.m0_done, bus.m1_done}, exp_sel); end
      end else begin
        checks++; if ({bus.m0_done, bus.m1_done} !== exp_sel || {bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin failures++; $display("FAIL rr_done[%0d]: got done=%b gnt=%b expected %b/00", k, {bus.m0_done, bus.m1_done}, {bus.m0_gnt, bus.m1_gnt}, exp_sel); end
        checks++; if (((exp_sel == 2'b10) ? bus.m0_rdata : bus.m1_rdata) !== exp_data) begin failures++; $display("FAIL rr_data[%0d]: got %h expected %h", k, (exp_sel == 2'b10) ? bus.m0_rdata : bus.m1_rdata, exp_data); end
      end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin failures++; $display("FAIL rr_stop: got %b expected 00", {bus.m0_gnt, bus.m1_gnt}); end
  endtask

  task automatic test_back_to_back;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h1001_0004;
    @(negedge clk);
    checks++; if (bus.m1_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt1: got %b expected 1", bus.m1_gnt); end
    @(negedge clk);
    checks++; if (bus.m1_done !== 1'b1 || bus.m1_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_done1: got done=%b rdata=%h expected 1/deadbeef", bus.m1_done, bus.m1_rdata); end
    bus.m1_addr = 32'h1001_000C;
    @(negedge clk);
    checks++; if (bus.m1_gnt !== 1'b1 || bus.m1_done !== 1'b0 || bus.Address_o !== 32'h1001_000C) begin failures++; $display("FAIL b2b_gnt2: got gnt=%b done=%b a=%h expected 1/0/1001000c", bus.m1_gnt, bus.m1_done, bus.Address_o); end
    bus.m1_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.m1_done !== 1'b1 || bus.m1_rdata !== 32'h1111_0003) begin failures++; $display("FAIL b2b_done2: got done=%b rdata=%h expected 1/11110003", bus.m1_done, bus.m1_rdata); end
    @(negedge clk);
    checks++; if ({bus.m1_gnt, bus.m1_done} !== 2'b00) begin failures++; $display("FAIL b2b_quiet: got %b expected 00", {bus.m1_gnt, bus.m1_done}); end
  endtask

  task automatic test_reset_during_access;
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h1001_0008; bus.m0_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (bus.m0_gnt !== 1'b1 || bus.Write_Enable_o !== 1'b1) begin failures++; $display("FAIL rst_acc_setup: got gnt=%b we=%b expected 1/1", bus.m0_gnt, bus.Write_Enable_o); end
    rst = 1'b1; bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    @(negedge clk);
    checks++; if (ram[2] !== 32'hCAFE_F00D) begin failures++; $display("FAIL rst_acc_commit: got %h expected cafef00d", ram[2]); end
    checks++; if ({bus.m0_done, bus.m0_gnt, bus.m1_gnt, bus.Write_Enable_o} !== 4'b0 || bus.Address_o !== 32'h0 || bus.m0_rdata !== 32'h0) begin failures++; $display("FAIL rst_acc_outputs: got %b a=%h rdata=%h expected 0000/0/0", {bus.m0_done, bus.m0_gnt, bus.m1_gnt, bus.Write_Enable_o}, bus.Address_o, bus.m0_rdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m0_done, bus.m0_gnt, bus.Write_Enable_o} !== 3'b0) begin failures++; $display("FAIL rst_acc_idle: got %b expected 000", {bus.m0_done, bus.m0_gnt, bus.Write_Enable_o}); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    outport  = 32'h0;
    inport   = 32'h1234_5678;
    for (int i = 0; i < 16; i++) ram[i] = 32'h1111_0000 + i;
    ram[1] = 32'hDEAD_BEEF;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;

    test_reset();
    test_m0_read();
    test_outport_write();
    test_misaligned();
    test_round_robin();
    test_back_to_back();
    test_reset_during_access();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
